// File: rtl/rr_operand_stage_if.sv
// Decode/register-file/forwarding/execute bundle for the register-read stage.
// The stage connects through the slave modport; the driving environment uses master.
interface rr_operand_stage_if #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
);
  logic          valid_in;
  logic [AW-1:0] rs_a;
  logic [AW-1:0] rs_b;
  logic          use_a;
  logic          use_b;
  logic [AW-1:0] rd_in;
  logic          wr_in;
  logic          ld_in;
  logic [3:0]    op_in;
  logic [DW-1:0] imm_in;
  logic [DW-1:0] pc_in;
  logic [AW-1:0] A1;
  logic [AW-1:0] A2;
  logic [DW-1:0] d_out1;
  logic [DW-1:0] d_out2;
  logic [AW-1:0] ex_rd;
  logic          ex_wr;
  logic          ex_ld;
  logic [DW-1:0] ex_res;
  logic [AW-1:0] mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_res;
  logic [AW-1:0] wb_rd;
  logic          wb_wr;
  logic [DW-1:0] wb_data;
  logic          ex_stall;
  logic          flush;
  logic          stall_out;
  logic          valid_out;
  logic [DW-1:0] opa_out;
  logic [DW-1:0] opb_out;
  logic [AW-1:0] rd_out;
  logic          wr_out;
  logic          ld_out;
  logic [3:0]    op_out;
  logic [DW-1:0] imm_out;
  logic [DW-1:0] pc_out;

  modport slave (
    input  valid_in, rs_a, rs_b, use_a, use_b, rd_in, wr_in, ld_in, op_in, imm_in, pc_in,
    input  d_out1, d_out2,
    input  ex_rd, ex_wr, ex_ld, ex_res, mem_rd, mem_wr, mem_res, wb_rd, wb_wr, wb_data,
    input  ex_stall, flush,
    output A1, A2, stall_out, valid_out, opa_out, opb_out,
    output rd_out, wr_out, ld_out, op_out, imm_out, pc_out
  );

  modport master (
    output valid_in, rs_a, rs_b, use_a, use_b, rd_in, wr_in, ld_in, op_in, imm_in, pc_in,
    output d_out1, d_out2,
    output ex_rd, ex_wr, ex_ld, ex_res, mem_rd, mem_wr, mem_res, wb_rd, wb_wr, wb_data,
    output ex_stall, flush,
    input  A1, A2, stall_out, valid_out, opa_out, opb_out,
    input  rd_out, wr_out, ld_out, op_out, imm_out, pc_out
  );
endinterface

// File: rtl/rr_operand_stage.sv
// Register-read stage: operand forwarding, load-use interlock and the RR/EX register.
// Define RR_WB_FWD_EN to add the write-back forwarding tier.
module rr_operand_stage #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  rr_operand_stage_if.slave bus
);
  localparam logic [AW-1:0] PC_REG = AW'(7);

  logic          valid_q, valid_d;
  logic [DW-1:0] opa_q, opa_d, opb_q, opb_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          wr_q, wr_d, ld_q, ld_d;
  logic [3:0]    op_q, op_d;
  logic [DW-1:0] imm_q, imm_d, pc_q, pc_d;
  logic [DW-1:0] opa_c, opb_c;
  logic          load_use_c;

  assign bus.A1 = bus.rs_a;
  assign bus.A2 = bus.rs_b;

`ifndef RR_WB_FWD_EN
  logic wb_unused;
  assign wb_unused = ^{bus.wb_rd, bus.wb_wr, bus.wb_data};
`endif

  // Operand A: PC, then EX (non-load), MEM, optionally WB, then register file
  always_comb begin
    opa_c = bus.d_out1;
    if (bus.rs_a == PC_REG)                                        opa_c = bus.pc_in;
    else if (bus.ex_wr && !bus.ex_ld && (bus.ex_rd == bus.rs_a))   opa_c = bus.ex_res;
    else if (bus.mem_wr && (bus.mem_rd == bus.rs_a))               opa_c = bus.mem_res;
`ifdef RR_WB_FWD_EN
    else if (bus.wb_wr && (bus.wb_rd == bus.rs_a))                 opa_c = bus.wb_data;
`endif
  end

  // Operand B: same priority chain
  always_comb begin
    opb_c = bus.d_out2;
    if (bus.rs_b == PC_REG)                                        opb_c = bus.pc_in;
    else if (bus.ex_wr && !bus.ex_ld && (bus.ex_rd == bus.rs_b))   opb_c = bus.ex_res;
    else if (bus.mem_wr && (bus.mem_rd == bus.rs_b))               opb_c = bus.mem_res;
`ifdef RR_WB_FWD_EN
    else if (bus.wb_wr && (bus.wb_rd == bus.rs_b))                 opb_c = bus.wb_data;
`endif
  end

  assign load_use_c = bus.valid_in & bus.ex_wr & bus.ex_ld &
                      ((bus.use_a & (bus.ex_rd == bus.rs_a) & (bus.rs_a != PC_REG)) |
                       (bus.use_b & (bus.ex_rd == bus.rs_b) & (bus.rs_b != PC_REG)));

  // Reset forces the decode-side stall low so decode is not held across reset
  assign bus.stall_out = ~rst & ~bus.flush & (bus.ex_stall | load_use_c);

  // Next-state: flush squashes, ex_stall holds, load-use bubbles, else capture
  always_comb begin
    valid_d = valid_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    ld_d    = ld_q;
    op_d    = op_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (bus.ex_stall) begin
      valid_d = valid_q;
    end else if (load_use_c) begin
      valid_d = 1'b0;
    end else begin
      valid_d = bus.valid_in;
      opa_d   = opa_c;
      opb_d   = opb_c;
      rd_d    = bus.rd_in;
      wr_d    = bus.wr_in;
      ld_d    = bus.ld_in;
      op_d    = bus.op_in;
      imm_d   = bus.imm_in;
      pc_d    = bus.pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      wr_q    <= 1'b0;
      ld_q    <= 1'b0;
      op_q    <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      ld_q    <= ld_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.opa_out   = opa_q;
  assign bus.opb_out   = opb_q;
  assign bus.rd_out    = rd_q;
  assign bus.wr_out    = wr_q;
  assign bus.ld_out    = ld_q;
  assign bus.op_out    = op_q;
  assign bus.imm_out   = imm_q;
  assign bus.pc_out    = pc_q;
endmodule

// File: tb/tb_rr_operand_stage.sv
// Bench for rr_operand_stage: directed vectors with literal expectations plus a
// per-cycle comparison against a rule-level model of the stage.
module tb_rr_operand_stage;
`ifdef RR_WB_FWD_EN
  localparam bit WB_ON = 1'b1;
`else
  localparam bit WB_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   chk_en = 1'b0;

  rr_operand_stage_if #(.DW(16), .AW(3)) bus ();
  rr_operand_stage #(.DW(16), .AW(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Model state of the RR/EX register
  logic        m_valid, m_wr, m_ld;
  logic [15:0] m_opa, m_opb, m_imm, m_pc;
  logic [2:0]  m_rd;
  logic [3:0]  m_op;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Operand for a source: first producer in priority order that writes it wins
  function automatic logic [15:0] m_resolve(input logic [2:0] s, input logic [15:0] rf);
    logic        hit [3];
    logic [15:0] val [3];
    if (s == 3'd7) return bus.pc_in;
    hit[0] = bus.ex_wr && !bus.ex_ld && bus.ex_rd == s;  val[0] = bus.ex_res;
    hit[1] = bus.mem_wr && bus.mem_rd == s;              val[1] = bus.mem_res;
    hit[2] = WB_ON && bus.wb_wr && bus.wb_rd == s;       val[2] = bus.wb_data;
    for (int i = 0; i < 3; i++) if (hit[i]) return val[i];
    return rf;
  endfunction

  function automatic logic m_load_use();
    logic ha, hb;
    ha = bus.use_a && bus.rs_a != 3'd7 && bus.rs_a == bus.ex_rd;
    hb = bus.use_b && bus.rs_b != 3'd7 && bus.rs_b == bus.ex_rd;
    return bus.valid_in && bus.ex_wr && bus.ex_ld && (ha || hb);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      {m_valid, m_wr, m_ld} = '0;
      {m_opa, m_opb, m_imm, m_pc} = '0;
      m_rd = '0; m_op = '0;
      chk_en = 1'b1;
    end else if (bus.flush) begin
      m_valid = 1'b0;
    end else if (!bus.ex_stall) begin
      if (m_load_use()) m_valid = 1'b0;
      else begin
        m_valid = bus.valid_in;
        m_opa = m_resolve(bus.rs_a, bus.d_out1);
        m_opb = m_resolve(bus.rs_b, bus.d_out2);
        m_rd = bus.rd_in; m_wr = bus.wr_in; m_ld = bus.ld_in;
        m_op = bus.op_in; m_imm = bus.imm_in; m_pc = bus.pc_in;
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_valid_out", 32'(bus.valid_out), 32'(m_valid));
      check("m_opa_out", 32'(bus.opa_out), 32'(m_opa));
      check("m_opb_out", 32'(bus.opb_out), 32'(m_opb));
      check("m_passthru", {bus.rd_out, bus.wr_out, bus.ld_out, bus.op_out},
            {m_rd, m_wr, m_ld, m_op});
      check("m_imm_pc", {bus.imm_out, bus.pc_out}, {m_imm, m_pc});
      check("m_addr", {bus.A1, bus.A2}, {bus.rs_a, bus.rs_b});
      check("m_stall_out", 32'(bus.stall_out),
            32'(!rst && !bus.flush && (bus.ex_stall || m_load_use())));
    end
  end

  task automatic idle();
    bus.valid_in = 0; bus.rs_a = 0; bus.rs_b = 0; bus.use_a = 0; bus.use_b = 0;
    bus.rd_in = 0; bus.wr_in = 0; bus.ld_in = 0; bus.op_in = 0; bus.imm_in = 0;
    bus.pc_in = 0; bus.d_out1 = 0; bus.d_out2 = 0;
    bus.ex_rd = 0; bus.ex_wr = 0; bus.ex_ld = 0; bus.ex_res = 0;
    bus.mem_rd = 0; bus.mem_wr = 0; bus.mem_res = 0;
    bus.wb_rd = 0; bus.wb_wr = 0; bus.wb_data = 0;
    bus.ex_stall = 0; bus.flush = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    bus.valid_in = 1; bus.rs_a = 1; bus.use_a = 1; bus.d_out1 = 16'h1234;
    cyc(); cyc();
    check("rst_valid", 32'(bus.valid_out), 0);
    check("rst_opa", 32'(bus.opa_out), 0);
    check("rst_stall", 32'(bus.stall_out), 0);
    rst = 1'b0;
    cyc();
    check("first_valid", 32'(bus.valid_out), 1);
    check("first_opa", 32'(bus.opa_out), 32'h1234);

    // Forwarding priority EX > MEM > register file
    idle();
    bus.valid_in = 1; bus.rs_a = 3; bus.use_a = 1; bus.d_out1 = 16'h1111;
    bus.mem_wr = 1; bus.mem_rd = 3; bus.mem_res = 16'h2222;
    bus.ex_wr = 1; bus.ex_ld = 0; bus.ex_rd = 3; bus.ex_res = 16'h3333;
    cyc();
    check("prio_ex", 32'(bus.opa_out), 32'h3333);
    bus.ex_wr = 0;
    cyc();
    check("prio_mem", 32'(bus.opa_out), 32'h2222);

    // Load-use bubble, then MEM forward
    idle();
    bus.valid_in = 1; bus.rs_b = 2; bus.use_b = 1; bus.d_out2 = 16'h0BAD;
    bus.ex_wr = 1; bus.ex_ld = 1; bus.ex_rd = 2;
    #1 check("lu_stall", 32'(bus.stall_out), 1);
    cyc();
    check("lu_bubble", 32'(bus.valid_out), 0);
    bus.ex_wr = 0; bus.ex_ld = 0;
    bus.mem_wr = 1; bus.mem_rd = 2; bus.mem_res = 16'hBEEF;
    #1 check("lu_release", 32'(bus.stall_out), 0);
    cyc();
    check("lu_valid", 32'(bus.valid_out), 1);
    check("lu_opb", 32'(bus.opb_out), 32'hBEEF);

    // R7 reads PC, no forwarding and no interlock
    idle();
    bus.valid_in = 1; bus.rs_a = 7; bus.use_a = 1; bus.pc_in = 16'h0040;
    bus.ex_rd = 7; bus.ex_wr = 1; bus.ex_res = 16'h9999;
    cyc();
    check("r7_opa", 32'(bus.opa_out), 32'h0040);
    bus.ex_ld = 1;
    #1 check("r7_no_stall", 32'(bus.stall_out), 0);
    cyc();
    check("r7_ld_valid", 32'(bus.valid_out), 1);

    // ex_stall holds for three cycles, then flush wins over stall
    idle();
    bus.valid_in = 1; bus.rs_a = 1; bus.use_a = 1; bus.d_out1 = 16'h5555; bus.ex_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", 32'(bus.stall_out), 1);
      cyc();
      check("hold_opa", 32'(bus.opa_out), 32'h0040);
      check("hold_valid", 32'(bus.valid_out), 1);
    end
    bus.flush = 1;
    #1 check("flush_stall", 32'(bus.stall_out), 0);
    cyc();
    check("flush_valid", 32'(bus.valid_out), 0);

    // Reset in the middle of a stall
    idle();
    bus.valid_in = 1; bus.rs_a = 1; bus.use_a = 1; bus.d_out1 = 16'h7777;
    cyc();
    bus.ex_stall = 1;
    cyc();
    check("mid_hold", 32'(bus.valid_out), 1);
    rst = 1'b1;
    #1 check("mid_rst_stall", 32'(bus.stall_out), 0);
    cyc();
    check("mid_rst_valid", 32'(bus.valid_out), 0);
    rst = 1'b0;

    // WB tier plus pass-through fields
    idle();
    bus.valid_in = 1; bus.rs_a = 5; bus.use_a = 1; bus.d_out1 = 16'h0000;
    bus.wb_wr = 1; bus.wb_rd = 5; bus.wb_data = 16'h00A5;
    bus.rd_in = 6; bus.wr_in = 1; bus.ld_in = 1; bus.op_in = 4'hA;
    bus.imm_in = 16'hFFF0; bus.pc_in = 16'h0100;
    cyc();
    check("wb_opa", 32'(bus.opa_out), WB_ON ? 32'h00A5 : 32'h0000);
    check("pass_fields", {bus.rd_out, bus.wr_out, bus.ld_out, bus.op_out}, {3'd6, 1'b1, 1'b1, 4'hA});
    check("pass_imm_pc", {bus.imm_out, bus.pc_out}, 32'hFFF00100);

    // Register 0 forwards like any other register
    idle();
    bus.valid_in = 1; bus.rs_b = 0; bus.use_b = 1; bus.d_out2 = 16'h1357;
    bus.mem_wr = 1; bus.mem_rd = 0; bus.mem_res = 16'h0F0F;
    cyc();
    check("r0_opb", 32'(bus.opb_out), 32'h0F0F);

    // Directed-random sweep covered by the per-cycle model comparison
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      bus.valid_in = $urandom_range(0, 1); bus.use_a = $urandom_range(0, 1);
      bus.use_b = $urandom_range(0, 1);
      bus.rs_a = 3'($urandom_range(0, 7)); bus.rs_b = 3'($urandom_range(0, 7));
      bus.rd_in = 3'($urandom_range(0, 7)); bus.wr_in = $urandom_range(0, 1);
      bus.ld_in = $urandom_range(0, 1); bus.op_in = 4'($urandom);
      bus.imm_in = 16'($urandom); bus.pc_in = 16'($urandom);
      bus.d_out1 = 16'($urandom); bus.d_out2 = 16'($urandom);
      bus.ex_rd = 3'($urandom_range(0, 7)); bus.ex_wr = $urandom_range(0, 1);
      bus.ex_ld = $urandom_range(0, 1); bus.ex_res = 16'($urandom);
      bus.mem_rd = 3'($urandom_range(0, 7)); bus.mem_wr = $urandom_range(0, 1);
      bus.mem_res = 16'($urandom);
      bus.wb_rd = 3'($urandom_range(0, 7)); bus.wb_wr = $urandom_range(0, 1);
      bus.wb_data = 16'($urandom);
      bus.ex_stall = ($urandom_range(0, 4) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      cyc();
    end
    rst = 1'b0;
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
